// File: rtl/add_round_key_if.sv
// Bus bundle for the word-serial AddRoundKey stage: the column/key inputs,
// the combinational column result and the assembled 128-bit block.
interface add_round_key_if;
  logic [31:0]  state_in;
  logic [31:0]  round_key;
  logic [31:0]  state_out;
  logic         in_valid;
  logic         blk_clear;
  logic [1:0]   word_cnt;
  logic [127:0] block_out;
  logic         block_valid;

  modport master (
    output state_in, round_key, in_valid, blk_clear,
    input  state_out, word_cnt, block_out, block_valid
  );

  modport slave (
    input  state_in, round_key, in_valid, blk_clear,
    output state_out, word_cnt, block_out, block_valid
  );
endinterface

// File: rtl/add_round_key.sv
// AES-128 AddRoundKey, one 32-bit column per cycle, with assembly of four
// XORed columns into a registered 128-bit block and a one-cycle done pulse.
module add_round_key (
  input  logic clk,
  input  logic rst_n,
  add_round_key_if.slave bus
);
  logic [1:0]   word_cnt_q, word_cnt_d;
  logic [31:0]  buf_q [3];
  logic [31:0]  buf_d [3];
  logic [127:0] block_out_q, block_out_d;
  logic         block_valid_q, block_valid_d;
  logic         capture;
  logic         last_word;

  assign bus.state_out   = bus.state_in ^ bus.round_key;
  assign bus.word_cnt    = word_cnt_q;
  assign bus.block_out   = block_out_q;
  assign bus.block_valid = block_valid_q;

  assign capture   = bus.in_valid && !bus.blk_clear;
  assign last_word = capture && (word_cnt_q == 2'd3);

  // Slot 3 is never buffered: it goes straight into block_out with slots 0..2.
  for (genvar gi = 0; gi < 3; gi++) begin : g_slot
    always_comb begin
      buf_d[gi] = buf_q[gi];
      if (bus.blk_clear) begin
        buf_d[gi] = '0;
      end else if (capture && (word_cnt_q == 2'(gi))) begin
        buf_d[gi] = bus.state_out;
      end
    end
  end

  always_comb begin
    word_cnt_d    = word_cnt_q;
    block_out_d   = block_out_q;
    block_valid_d = 1'b0;
    if (bus.blk_clear) begin
      word_cnt_d = 2'd0;
    end else if (capture) begin
      word_cnt_d = word_cnt_q + 2'd1;
      if (last_word) begin
        block_out_d   = {buf_q[0], buf_q[1], buf_q[2], bus.state_out};
        block_valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      word_cnt_q    <= 2'd0;
      block_out_q   <= '0;
      block_valid_q <= 1'b0;
      for (int i = 0; i < 3; i++) buf_q[i] <= '0;
    end else begin
      word_cnt_q    <= word_cnt_d;
      block_out_q   <= block_out_d;
      block_valid_q <= block_valid_d;
      for (int i = 0; i < 3; i++) buf_q[i] <= buf_d[i];
    end
  end
endmodule

// File: tb/tb_add_round_key.sv
// Directed bench for add_round_key: a reference model predicts word_cnt,
// block_out and block_valid each cycle; completed blocks go through a queue.
module tb_add_round_key;
  logic clk;
  logic rst_n;
  add_round_key_if bus ();

  add_round_key dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int last_valid_cyc = -1;
  bit stream_mode = 1'b0;

  logic [127:0] exp_q [$];
  logic [1:0]   m_cnt = 2'd0;
  logic [31:0]  m_buf [3];
  logic [127:0] m_block = '0;
  logic         m_valid = 1'b0;

  logic [31:0] vec_s [4] = '{32'haaaaaaaa, 32'h00000000, 32'h12345678, 32'hdeadbeef};
  logic [31:0] vec_k [4] = '{32'h55555555, 32'hffffffff, 32'h87654321, 32'hfeedface};
  logic [31:0] vec_x [4] = '{32'hffffffff, 32'hffffffff, 32'h95511559, 32'h20404421};
  logic [127:0] vec_block = 128'hffffffff_ffffffff_95511559_20404421;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, check state_out, advance model, check outputs.
  task automatic step(input logic rst, input logic v, input logic clr,
                      input logic [31:0] s, input logic [31:0] k);
    logic [127:0] popped;
    rst_n = rst;
    bus.in_valid = v;
    bus.blk_clear = clr;
    bus.state_in = s;
    bus.round_key = k;
    #1;
    chk("state_out", {96'd0, bus.state_out}, {96'd0, s ^ k});
    if (!rst) begin
      m_cnt = 2'd0; m_block = '0; m_valid = 1'b0;
      for (int i = 0; i < 3; i++) m_buf[i] = '0;
    end else if (clr) begin
      m_cnt = 2'd0; m_valid = 1'b0;
      for (int i = 0; i < 3; i++) m_buf[i] = '0;
    end else if (v) begin
      if (m_cnt == 2'd3) begin
        m_block = {m_buf[0], m_buf[1], m_buf[2], s ^ k};
        exp_q.push_back(m_block);
        m_valid = 1'b1;
        m_cnt = 2'd0;
      end else begin
        m_buf[m_cnt] = s ^ k;
        m_cnt = m_cnt + 2'd1;
        m_valid = 1'b0;
      end
    end else begin
      m_valid = 1'b0;
    end
    @(posedge clk);
    #1;
    cyc++;
    chk("word_cnt", {126'd0, bus.word_cnt}, {126'd0, m_cnt});
    chk("block_valid", {127'd0, bus.block_valid}, {127'd0, m_valid});
    chk("block_out_hold", bus.block_out, m_block);
    if (bus.block_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_block", bus.block_out, '1 ^ bus.block_out);
      end else begin
        popped = exp_q.pop_front();
        chk("scoreboard_block", bus.block_out, popped);
      end
      if (stream_mode && last_valid_cyc >= 0)
        chk("pulse_gap", 128'(cyc - last_valid_cyc), 128'd4);
      last_valid_cyc = cyc;
    end
  endtask

  initial begin
    logic [127:0] saved;
    logic [31:0] rs, rk;
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.blk_clear = 1'b0;
    bus.state_in = '0;
    bus.round_key = '0;
    for (int i = 0; i < 3; i++) m_buf[i] = '0;
    @(posedge clk);
    #1;

    // Combinational vectors while held in reset
    for (int i = 0; i < 4; i++) begin
      bus.state_in = vec_s[i];
      bus.round_key = vec_k[i];
      #1;
      chk("comb_in_reset", {96'd0, bus.state_out}, {96'd0, vec_x[i]});
    end
    step(1'b0, 1'b1, 1'b0, 32'h0, 32'h0);
    chk("reset_block_out", bus.block_out, 128'd0);

    // Back-to-back block
    for (int i = 0; i < 4; i++) begin
      bus.state_in = vec_s[i];
      bus.round_key = vec_k[i];
      #1;
      chk("comb_vector", {96'd0, bus.state_out}, {96'd0, vec_x[i]});
      step(1'b1, 1'b1, 1'b0, vec_s[i], vec_k[i]);
    end
    chk("b2b_block", bus.block_out, vec_block);
    step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);

    // Gapped block
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b1, 1'b0, vec_s[i], vec_k[i]);
      step(1'b1, 1'b0, 1'b0, 32'h11111111, 32'h22222222);
      step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    end
    chk("gapped_block", bus.block_out, vec_block);

    // blk_clear mid-block, simultaneous with in_valid
    saved = bus.block_out;
    step(1'b1, 1'b1, 1'b0, 32'h01020304, 32'h0);
    step(1'b1, 1'b1, 1'b0, 32'h05060708, 32'h0);
    step(1'b1, 1'b1, 1'b1, 32'hcafef00d, 32'h0);
    chk("clear_cnt", {126'd0, bus.word_cnt}, 128'd0);
    chk("clear_keeps_block", bus.block_out, saved);
    step(1'b1, 1'b1, 1'b0, 32'ha0a0a0a0, 32'h0a0a0a0a);
    step(1'b1, 1'b1, 1'b0, 32'h00000001, 32'h00000002);
    step(1'b1, 1'b1, 1'b0, 32'hffff0000, 32'h0000ffff);
    step(1'b1, 1'b1, 1'b0, 32'h80000000, 32'h00000001);
    chk("post_clear_block", bus.block_out,
        128'haaaaaaaa_00000003_ffffffff_80000001);

    // Reset mid-block
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, vec_s[i], vec_k[i]);
    step(1'b0, 1'b1, 1'b0, 32'h0f0f0f0f, 32'hf0f0f0f0);
    chk("reset_mid_block_out", bus.block_out, 128'd0);
    chk("reset_mid_cnt", {126'd0, bus.word_cnt}, 128'd0);
    chk("reset_comb", {96'd0, bus.state_out}, 128'hffffffff);

    // Continuous stream of three random blocks
    stream_mode = 1'b1;
    last_valid_cyc = -1;
    for (int i = 0; i < 12; i++) begin
      rs = $urandom;
      rk = $urandom;
      step(1'b1, 1'b1, 1'b0, rs, rk);
    end
    stream_mode = 1'b0;
    step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    chk("queue_drained", 128'(exp_q.size()), 128'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/add_round_key.md
# add_round_key

Word-level AES-128 AddRoundKey stage. Each cycle it XORs one 32-bit state column with the matching 32-bit round-key word, and offers the result combinationally. It also assembles the four XORed columns of a block into a registered 128-bit result with a completion pulse. It sits between MixColumns (or the input whitening path) and the next round's SubBytes in a word-serial AES-128 datapath.

## Interface
Parameters:
- none; all widths are fixed by AES-128.

Ports:
- Clocking: one clock; reset is synchronous and active-low (clk, rst_n).
- clk  input  1  rising-edge clock for all registers.
- rst_n  input  1  synchronous active-low reset.
- state_in  input  32  state column; byte 0 is [31:24].
- round_key  input  32  round-key word for the same column.
- state_out  output  32  combinational state_in ^ round_key.
- in_valid  input  1  capture the current state_out word into the block register.
- blk_clear  input  1  synchronous restart of block assembly.
- word_cnt  output  2  number of words captured in the current block (0-3).
- block_out  output  128  last completed 128-bit AddRoundKey result.
- block_valid  output  1  one-cycle pulse when block_out has just been updated.

## Operation
- state_out = state_in ^ round_key, bitwise.
  - Purely combinational, with no dependence on clk, rst_n, in_valid or the block state.
  - Valid during reset.
- Block assembly, on a rising clk edge with rst_n=1, blk_clear=0, in_valid=1:
  - The word is written into an internal assembly buffer at slot word_cnt.
  - Slot 0 maps to bits [127:96], slot 1 to [95:64], slot 2 to [63:32] and slot 3 to [31:0].
  - word_cnt then increments modulo 4.
- When the word captured is slot 3 (word_cnt==3 and in_valid=1):
  - block_out loads all four slots on that edge: the three buffered words plus the current word in [31:0].
  - block_valid is 1 for exactly the following cycle.
  - word_cnt wraps to 0.
- in_valid=0: no capture. word_cnt, buffer and block_out hold, and block_valid is 0.
- block_out holds its value until the next block completes. Partial blocks never alter block_out.
- blk_clear=1 (with rst_n=1):
  - word_cnt goes to 0, the buffered partial words are discarded, and block_valid goes to 0.
  - block_out is kept.
  - blk_clear has priority over a simultaneous in_valid, and that word is dropped.
- Reset (rst_n=0 at an edge):
  - word_cnt=0, buffer=0, block_out=0, block_valid=0.
  - Reset overrides blk_clear and in_valid. A partial block in progress is lost.
- There is no back-pressure. A word is accepted on every cycle that in_valid=1.

## Timing
- state_out: zero-cycle latency, combinational.
- Block: block_out and block_valid update on the edge that captures word 3.
  - Latency is 4 accepting edges from the first word of a block.
  - With in_valid held high, one block completes every 4 cycles and block_valid pulses every 4th cycle.
- Idle cycles (in_valid=0) may be inserted between any words without affecting the result.
- All outputs except state_out are registered. After the first post-reset edge, every output has a defined (non-X) value.

## Test plan
- Combinational vectors, checked 1 time unit after applying inputs, in and out of reset:
  - aaaaaaaa ^ 55555555 -> ffffffff
  - 00000000 ^ ffffffff -> ffffffff
  - 12345678 ^ 87654321 -> 95511559
  - deadbeef ^ feedface -> 20404421
- Back-to-back block: apply the four vectors above with in_valid=1 for 4 cycles.
  - Required: block_out = ffffffff_ffffffff_95511559_20404421.
  - block_valid high for exactly one cycle, and word_cnt sequence 0,1,2,3,0.
- Gapped block: same words with in_valid=0 cycles between them -> identical block_out, and a single block_valid pulse after the 4th word.
- blk_clear mid-block: capture 2 words, then assert blk_clear together with in_valid=1.
  - Required: word_cnt=0, previous block_out unchanged, no block_valid.
  - A subsequent 4 words produce a block containing only the new words.
- Reset mid-block: capture 3 words, then pull rst_n low for 1 cycle.
  - Required: block_out=0, word_cnt=0, block_valid=0.
  - state_out still tracks its inputs during reset.
- Continuous stream: 3 consecutive blocks of random words -> each block_out equals the bitwise XOR of its inputs, with block_valid pulses 4 cycles apart.
